agc_wb_sequencer: RTL and testbench
===================================

# agc_wb_sequencer

Wishbone initiator that runs one complete AGC measurement cycle against the AGC register target and returns the accumulator results. It sits on the `wb_clk_i` domain, on the same 8-bit-address, 32-bit-data Wishbone bus as the AGC target. On request it can load a new scale and offset first. It then issues the tick, polls for completion, and reads the square, greater-than and less-than accumulators, so software or a higher-level loop controller sees a single start/done handshake.

## Interface
Parameters:
- `ACK_TIMEOUT`, 64: cycles a transaction waits for `wb_ack_i` before it is aborted.
- `POLL_INTERVAL`, 256: idle cycles between status reads.
- `POLL_LIMIT`, 4096: maximum status reads before a poll timeout.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone initiator strobes.
- `wb_adr_o` out 8: byte address.
- `wb_dat_o` out 32: write data.
- `wb_sel_o` out 4: byte selects.
- `wb_dat_i` in 32: read data.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i` in 1: target responses. `rty` is treated as `err`.
- `start_i` in 1: single-cycle request, sampled only in IDLE.
- `load_i` in 1: sampled with `start_i`. When 1, the scale, offset and apply writes precede the tick.
- `scale_i` in 17, `offset_i` in 16: values captured with `start_i`.
- `busy_o` out 1: high from the cycle after an accepted start until `done_o`.
- `done_o` out 1: one-cycle pulse at the end of a run.
- `status_o` out 2: 0 = ok, 1 = bus error, 2 = ack timeout, 3 = poll timeout. Held until the next accepted start.
- `sq_o` out 25, `gt_o` out 21, `lt_o` out 21: accumulator results. Updated only on successful reads.

## Operation
Target register map:
- 0x00 control/status.
  - Write bits: bit0 tick, bit2 reset, bit8 load scale, bit9 load offset, bit10 apply.
  - Read bit: bit1 done.
- 0x04 sq[24:0], 0x08 gt[20:0], 0x0C lt[20:0], 0x10 scale[16:0], 0x14 offset[15:0].

Run sequence. Each step is one single-beat transaction.
- If `load_i`:
  - WR_SCALE: adr 0x10, dat `{15'b0,scale}`, sel 0111.
  - WR_OFFSET: adr 0x14, dat `{16'b0,offset}`, sel 0011.
  - WR_APPLY: adr 0x00, dat 0x00000700, sel 0010.
- WR_TICK: adr 0x00, dat 0x00000001, sel 0001.
- POLL_WAIT: counts `POLL_INTERVAL` cycles.
- RD_STAT: adr 0x00, read.
  - If `wb_dat_i[1]` = 1, go to RD_SQ.
  - Otherwise increment the poll count and return to POLL_WAIT. Reaching `POLL_LIMIT` reads ends the run with status 3.
- RD_SQ, RD_GT, RD_LT: capture `wb_dat_i[24:0]`, `[20:0]` and `[20:0]` into `sq_o`, `gt_o` and `lt_o`.
- DONE: `done_o` = 1 for one cycle, status 0, return to IDLE.

Abort conditions:
- `wb_err_i` or `wb_rty_i` sampled while `wb_stb_o` is high: drop the cycle, status 1, DONE.
- No ack within `ACK_TIMEOUT` cycles of assertion: drop the cycle, status 2, DONE.
- The result registers keep their previous values on any abort.

Other rules:
- `start_i` while busy is ignored. `start_i` and `load_i` are not queued.
- `scale_i` and `offset_i` are captured at start. Later changes do not affect the run in progress.

## Timing
- Reset value of every output is 0.
- Asynchronous reset mid-transaction drops `wb_cyc_o` and `wb_stb_o` immediately and returns the FSM to IDLE. No `done_o` is produced.
- Accepted start at cycle n: `wb_cyc_o` and `wb_stb_o` go high at n+1.
- `wb_cyc_o`, `wb_stb_o`, `wb_adr_o`, `wb_we_o`, `wb_sel_o` and `wb_dat_o` are registered and held stable until the cycle in which `wb_ack_i` is sampled high. The target decodes the address several cycles after `stb`, so stability is mandatory.
- The strobes deassert on the cycle after the ack edge.
- A minimum of one bus-idle cycle separates transactions.
- Against the AGC target (ack 2 cycles after `stb`), one transaction occupies 4 cycles including the gap.
- Read data is captured on the ack edge.
- `done_o` asserts the cycle after the ack of RD_LT, or the cycle after the abort. `busy_o` falls with `done_o`.
- The ack-timeout counter restarts for every transaction. The `POLL_INTERVAL` count starts after the gap cycle.
- Ack and err arriving together: err wins.

## Structure
- Package `agc_wb_pkg` holds:
  - the register address constants;
  - the control bit positions;
  - the status codes;
  - the FSM state enum (IDLE, WR_SCALE, WR_OFFSET, WR_APPLY, WR_TICK, POLL_WAIT, RD_STAT, RD_SQ, RD_GT, RD_LT, DONE).
- Sub-module `wb_master_xact` is a single-beat engine.
  - Inputs: req, we, adr, dat and sel.
  - Outputs: rdata, ok, err and timeout.
  - It owns the ack timeout and the gap cycle.
  - The sequencer FSM issues one request per state.

## Test plan
- Start with `load_i` = 0 against a model target that sets done after 3 polls:
  - Bus shows write 0x00/0x00000001/sel 0001, then 3 reads of 0x00, then reads of 0x04, 0x08 and 0x0C.
  - Returned values 0x1ABCDEF, 0x012345 and 0x054321 appear on `sq_o`, `gt_o` and `lt_o`.
  - `done_o` pulses once with status 0.
- Start with `load_i` = 1, scale 0x1FFFF, offset 0x8001:
  - Writes are 0x10/0x0001FFFF/sel 0111, 0x14/0x00008001/sel 0011 and 0x00/0x00000700/sel 0010, in that order, before the tick.
- Target never asserts ack on the first write:
  - Strobes drop after 64 cycles, status 2, `done_o` pulses.
  - Results are unchanged.
- Target returns `wb_err_i` on the RD_GT read:
  - Status 1.
  - `sq_o` is updated; `gt_o` and `lt_o` keep their prior values.
- Done never set, with `POLL_LIMIT` = 4:
  - Exactly 4 status reads, status 3.
- Assert `wb_rst_i` while `stb` is high mid-poll:
  - Outputs are 0 immediately and no `done_o` is produced.
  - A new start completes normally.
  - `start_i` pulsed while busy produces no second run.

Source files
------------

// File: rtl/agc_wb_pkg.sv
// Shared definitions for the AGC Wishbone sequencer: target register map, control bits,
// run status codes, sequencer states and the per-step bus request builder.
package agc_wb_pkg;

  localparam logic [7:0] AdrCtrl   = 8'h00;
  localparam logic [7:0] AdrSq     = 8'h04;
  localparam logic [7:0] AdrGt     = 8'h08;
  localparam logic [7:0] AdrLt     = 8'h0C;
  localparam logic [7:0] AdrScale  = 8'h10;
  localparam logic [7:0] AdrOffset = 8'h14;

  localparam int unsigned CtrlTick     = 0;
  localparam int unsigned CtrlDone     = 1;
  localparam int unsigned CtrlReset    = 2;
  localparam int unsigned CtrlLdScale  = 8;
  localparam int unsigned CtrlLdOffset = 9;
  localparam int unsigned CtrlApply    = 10;

  typedef enum logic [1:0] {
    StatusOk      = 2'd0,
    StatusBusErr  = 2'd1,
    StatusAckTmo  = 2'd2,
    StatusPollTmo = 2'd3
  } status_e;

  typedef enum logic [3:0] {
    StIdle,
    StWrScale,
    StWrOffset,
    StWrApply,
    StWrTick,
    StPollWait,
    StRdStat,
    StRdSq,
    StRdGt,
    StRdLt,
    StDone
  } state_e;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } xact_req_t;

  // Bus transaction issued on entry to a sequencer step; non-bus steps map to a harmless read.
  function automatic xact_req_t step_req(state_e st, logic [16:0] scale, logic [15:0] offset);
    xact_req_t r;
    r     = '0;
    r.adr = AdrCtrl;
    r.sel = 4'hF;
    case (st)
      StWrScale: begin
        r.we  = 1'b1;
        r.adr = AdrScale;
        r.dat = {15'b0, scale};
        r.sel = 4'b0111;
      end
      StWrOffset: begin
        r.we  = 1'b1;
        r.adr = AdrOffset;
        r.dat = {16'b0, offset};
        r.sel = 4'b0011;
      end
      StWrApply: begin
        r.we                = 1'b1;
        r.dat[CtrlLdScale]  = 1'b1;
        r.dat[CtrlLdOffset] = 1'b1;
        r.dat[CtrlApply]    = 1'b1;
        r.sel               = 4'b0010;
      end
      StWrTick: begin
        r.we            = 1'b1;
        r.dat[CtrlTick] = 1'b1;
        r.sel           = 4'b0001;
      end
      StRdSq:  r.adr = AdrSq;
      StRdGt:  r.adr = AdrGt;
      StRdLt:  r.adr = AdrLt;
      default: r.adr = AdrCtrl;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_master_xact.sv
// Single-beat Wishbone initiator: registers one request, holds it until ack/err/timeout,
// and reports the outcome combinationally in the cycle the response is sampled.
module wb_master_xact #(
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        ok_o,
  output logic        err_o,
  output logic        timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ACK_TIMEOUT - 1);

  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [7:0]      adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            fail;

  always_comb begin
    fail      = wb_err_i | wb_rty_i;
    err_o     = cyc_q & fail;
    ok_o      = cyc_q & wb_ack_i & ~fail;
    timeout_o = cyc_q & ~wb_ack_i & ~fail & (tmo_q == TmoLast);
    ready_o   = ~cyc_q;
    rdata_o   = wb_dat_i;

    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    tmo_d = tmo_q;
    if (cyc_q) begin
      // Dropping cyc here guarantees at least one idle cycle before the next request lands.
      if (ok_o || err_o || timeout_o) begin
        cyc_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else if (req_i) begin
      cyc_d = 1'b1;
      tmo_d = '0;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = dat_i;
      sel_d = sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      tmo_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      tmo_q <= tmo_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

endmodule

// File: rtl/agc_wb_sequencer.sv
// Runs one AGC measurement cycle over Wishbone (optional load, tick, poll, three reads)
// behind a single start/done handshake.
module agc_wb_sequencer
  import agc_wb_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT   = 64,
  parameter int unsigned POLL_INTERVAL = 256,
  parameter int unsigned POLL_LIMIT    = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic        start_i,
  input  logic        load_i,
  input  logic [16:0] scale_i,
  input  logic [15:0] offset_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  status_o,
  output logic [24:0] sq_o,
  output logic [20:0] gt_o,
  output logic [20:0] lt_o
);

  localparam int unsigned PivW  = $clog2(POLL_INTERVAL + 1);
  localparam int unsigned PcntW = $clog2(POLL_LIMIT + 1);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic             issued_q, issued_d;
  logic [16:0]      scale_q, scale_d;
  logic [15:0]      offset_q, offset_d;
  logic [PivW-1:0]  piv_q, piv_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [24:0]      sq_q, sq_d;
  logic [20:0]      gt_q, gt_d;
  logic [20:0]      lt_q, lt_d;

  logic        req;
  xact_req_t   req_fields;
  logic [16:0] scale_mux;
  logic [15:0] offset_mux;
  logic        x_ready, x_ok, x_err, x_tmo;
  logic [31:0] x_rdata;
  logic        unused_rdata;

  assign unused_rdata = ^x_rdata[31:25];

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    issued_d = issued_q;
    scale_d  = scale_q;
    offset_d = offset_q;
    piv_d    = piv_q;
    pcnt_d   = pcnt_q;
    sq_d     = sq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    req      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = load_i ? StWrScale : StWrTick;
          scale_d  = scale_i;
          offset_d = offset_i;
          status_d = StatusOk;
          pcnt_d   = '0;
          req      = 1'b1;
          issued_d = 1'b1;
        end
      end
      StPollWait: begin
        // First cycle here is the bus gap after the previous ack; the interval follows it.
        if (piv_q == PivW'(POLL_INTERVAL)) begin
          state_d  = StRdStat;
          req      = 1'b1;
          issued_d = 1'b1;
        end else begin
          piv_d = piv_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      StWrScale, StWrOffset, StWrApply, StWrTick, StRdStat, StRdSq, StRdGt, StRdLt: begin
        if (x_err) begin
          state_d  = StDone;
          status_d = StatusBusErr;
        end else if (x_tmo) begin
          state_d  = StDone;
          status_d = StatusAckTmo;
        end else if (x_ok) begin
          issued_d = 1'b0;
          case (state_q)
            StWrScale:  state_d = StWrOffset;
            StWrOffset: state_d = StWrApply;
            StWrApply:  state_d = StWrTick;
            StWrTick: begin
              state_d = StPollWait;
              piv_d   = '0;
            end
            StRdStat: begin
              if (x_rdata[CtrlDone]) begin
                state_d = StRdSq;
              end else if (pcnt_q == PcntW'(POLL_LIMIT - 1)) begin
                state_d  = StDone;
                status_d = StatusPollTmo;
              end else begin
                pcnt_d  = pcnt_q + 1'b1;
                state_d = StPollWait;
                piv_d   = '0;
              end
            end
            StRdSq: begin
              sq_d    = x_rdata[24:0];
              state_d = StRdGt;
            end
            StRdGt: begin
              gt_d    = x_rdata[20:0];
              state_d = StRdLt;
            end
            default: begin
              lt_d     = x_rdata[20:0];
              state_d  = StDone;
              status_d = StatusOk;
            end
          endcase
        end else if (!issued_q && x_ready) begin
          req      = 1'b1;
          issued_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // The request always describes the step being entered, so IDLE uses the live inputs.
    scale_mux  = (state_q == StIdle) ? scale_i : scale_q;
    offset_mux = (state_q == StIdle) ? offset_i : offset_q;
    req_fields = step_req(state_d, scale_mux, offset_mux);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      status_q <= StatusOk;
      issued_q <= 1'b0;
      scale_q  <= '0;
      offset_q <= '0;
      piv_q    <= '0;
      pcnt_q   <= '0;
      sq_q     <= '0;
      gt_q     <= '0;
      lt_q     <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      issued_q <= issued_d;
      scale_q  <= scale_d;
      offset_q <= offset_d;
      piv_q    <= piv_d;
      pcnt_q   <= pcnt_d;
      sq_q     <= sq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  wb_master_xact #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xact (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req_i    (req),
    .we_i     (req_fields.we),
    .adr_i    (req_fields.adr),
    .dat_i    (req_fields.dat),
    .sel_i    (req_fields.sel),
    .ready_o  (x_ready),
    .rdata_o  (x_rdata),
    .ok_o     (x_ok),
    .err_o    (x_err),
    .timeout_o(x_tmo),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i),
    .wb_rty_i (wb_rty_i)
  );

  assign busy_o   = (state_q != StIdle) && (state_q != StDone);
  assign done_o   = (state_q == StDone);
  assign status_o = status_q;
  assign sq_o     = sq_q;
  assign gt_o     = gt_q;
  assign lt_o     = lt_q;

endmodule

// File: tb/tb_agc_wb_sequencer.sv
// Randomized bench for agc_wb_sequencer against a behavioural AGC target and run model.
module tb_agc_wb_sequencer;

  localparam int unsigned AckTo   = 64;
  localparam int unsigned PollIv  = 8;
  localparam int unsigned PollLim = 4;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic        start_i = 1'b0, load_i = 1'b0;
  logic [16:0] scale_i = '0;
  logic [15:0] offset_i = '0;
  logic        busy_o, done_o;
  logic [1:0]  status_o;
  logic [24:0] sq_o;
  logic [20:0] gt_o, lt_o;

  always #5 wb_clk_i = ~wb_clk_i;

  agc_wb_sequencer #(
    .ACK_TIMEOUT  (AckTo),
    .POLL_INTERVAL(PollIv),
    .POLL_LIMIT   (PollLim)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o (wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i),
    .start_i (start_i),
    .load_i  (load_i),
    .scale_i (scale_i),
    .offset_i(offset_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .status_o(status_o),
    .sq_o    (sq_o),
    .gt_o    (gt_o),
    .lt_o    (lt_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Target model configuration and observations.
  int          done_on = 0;
  bit          hang = 1'b0, err_with_ack = 1'b0, use_rty = 1'b0;
  logic [7:0]  err_adr = 8'hFF;
  logic [31:0] t_sq = '0, t_gt = '0, t_lt = '0;
  int          polls_seen = 0, n_resp = 0, age = 0, last_len = 0, stab_bad = 0;
  longint      cyc_cnt = 0, resp_cyc = 0;
  txn_t        snap;
  txn_t        log_q[$];

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // Target: acks 2 cycles after stb rises, logs each answered transaction.
  initial begin
    forever begin
      txn_t cur;
      @(posedge wb_clk_i);
      #1;
      cur = {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
      if (wb_cyc_o !== wb_stb_o) stab_bad++;
      if (wb_stb_o === 1'b1) begin
        age++;
        if (age == 1) snap = cur;
        else if (cur !== snap) stab_bad++;
        if (age == 3 && !(hang && n_resp == 0)) begin
          n_resp++;
          resp_cyc = cyc_cnt;
          log_q.push_back(cur);
          if (cur.adr == err_adr) begin
            if (use_rty) wb_rty_i = 1'b1;
            else wb_err_i = 1'b1;
            wb_ack_i = err_with_ack;
          end else begin
            wb_ack_i = 1'b1;
          end
          if (!cur.we) begin
            case (cur.adr)
              8'h00: begin
                polls_seen++;
                wb_dat_i = $urandom & ~32'h2;
                if (done_on != 0 && polls_seen >= done_on) wb_dat_i[1] = 1'b1;
              end
              8'h04:   wb_dat_i = t_sq;
              8'h08:   wb_dat_i = t_gt;
              8'h0C:   wb_dat_i = t_lt;
              default: wb_dat_i = $urandom;
            endcase
          end
        end
      end else begin
        if (age != 0) last_len = age;
        age = 0;
      end
    end
  end

  // Run model: expected bus transactions, status and result registers.
  txn_t        exp_q[$];
  logic [1:0]  exp_status = 2'd0;
  logic [24:0] exp_sq = '0;
  logic [20:0] exp_gt = '0, exp_lt = '0;

  function automatic bit step(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel);
    if (hang && exp_q.size() == 0) begin
      exp_status = 2'd2;
      return 1'b0;
    end
    exp_q.push_back({we, adr, dat, sel});
    if (adr == err_adr) begin
      exp_status = 2'd1;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic build_expect(input bit ld, input logic [16:0] sc, input logic [15:0] of);
    bit ok, reached;
    ok = 1'b1;
    reached = 1'b0;
    exp_q.delete();
    exp_status = 2'd0;
    if (ld) begin
      ok = step(1'b1, 8'h10, {15'b0, sc}, 4'b0111);
      if (ok) ok = step(1'b1, 8'h14, {16'b0, of}, 4'b0011);
      if (ok) ok = step(1'b1, 8'h00, 32'h0000_0700, 4'b0010);
    end
    if (ok) ok = step(1'b1, 8'h00, 32'h0000_0001, 4'b0001);
    for (int i = 1; i <= int'(PollLim) && ok && !reached; i++) begin
      ok = step(1'b0, 8'h00, 32'h0, 4'hF);
      if (ok && done_on != 0 && i >= done_on) reached = 1'b1;
    end
    if (ok && !reached) exp_status = 2'd3;
    if (ok && reached) begin
      if (step(1'b0, 8'h04, 32'h0, 4'hF)) begin
        exp_sq = t_sq[24:0];
        if (step(1'b0, 8'h08, 32'h0, 4'hF)) begin
          exp_gt = t_gt[20:0];
          if (step(1'b0, 8'h0C, 32'h0, 4'hF)) exp_lt = t_lt[20:0];
        end
      end
    end
  endtask

  task automatic run_case(input bit ld, input logic [16:0] sc, input logic [15:0] of,
                          input int don, input bit hg, input logic [7:0] ea, input bit ewa,
                          input bit rty, input logic [31:0] tsq, input logic [31:0] tgt,
                          input logic [31:0] tlt);
    bit     got;
    int     extra;
    longint done_cyc;
    done_on = don; hang = hg; err_adr = ea; err_with_ack = ewa; use_rty = rty;
    t_sq = tsq; t_gt = tgt; t_lt = tlt;
    polls_seen = 0; n_resp = 0; stab_bad = 0; last_len = 0;
    log_q.delete();
    build_expect(ld, sc, of);

    @(negedge wb_clk_i);
    start_i = 1'b1; load_i = ld; scale_i = sc; offset_i = of;
    @(negedge wb_clk_i);
    start_i = 1'b0; load_i = 1'($urandom); scale_i = 17'($urandom); offset_i = 16'($urandom);
    check_eq("cyc_after_start", 32'(wb_cyc_o), 32'd1);
    check_eq("busy_after_start", 32'(busy_o), 32'd1);

    got = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge wb_clk_i);
      if (done_o) begin
        got = 1'b1;
        done_cyc = cyc_cnt;
      end
      start_i = (k == 6) && busy_o;
    end
    start_i = 1'b0;
    check_eq("done_seen", 32'(got), 32'd1);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge wb_clk_i);
      if (done_o) extra++;
    end
    check_eq("extra_done", 32'(extra), 32'd0);
    check_eq("busy_after", 32'(busy_o), 32'd0);
    check_eq("status", 32'(status_o), 32'(exp_status));
    check_eq("sq", 32'(sq_o), 32'(exp_sq));
    check_eq("gt", 32'(gt_o), 32'(exp_gt));
    check_eq("lt", 32'(lt_o), 32'(exp_lt));
    check_eq("n_txn", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check_eq($sformatf("txn%0d_we", i), 32'(log_q[i].we), 32'(exp_q[i].we));
      check_eq($sformatf("txn%0d_adr", i), 32'(log_q[i].adr), 32'(exp_q[i].adr));
      if (exp_q[i].we) begin
        check_eq($sformatf("txn%0d_dat", i), log_q[i].dat, exp_q[i].dat);
        check_eq($sformatf("txn%0d_sel", i), 32'(log_q[i].sel), 32'(exp_q[i].sel));
      end
    end
    if (hg) check_eq("stb_len", 32'(last_len), 32'(AckTo));
    else if (got) check_eq("done_latency", 32'(done_cyc - resp_cyc), 32'd1);
    check_eq("bus_stable", 32'(stab_bad), 32'd0);
  endtask

  initial begin
    logic [7:0] adrs[6];
    bit         found;
    int         ndone;
    adrs = '{8'h10, 8'h14, 8'h00, 8'h04, 8'h08, 8'h0C};

    #1;
    check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_status", 32'(status_o), 32'd0);
    check_eq("rst_sq", 32'(sq_o), 32'd0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    run_case(1'b0, 17'h0, 16'h0, 3, 1'b0, 8'hFF, 1'b0, 1'b0,
             32'h01AB_CDEF, 32'h0001_2345, 32'h0005_4321);
    run_case(1'b1, 17'h1FFFF, 16'h8001, 1, 1'b0, 8'hFF, 1'b0, 1'b0,
             32'hFFAA_5555, 32'hFF1F_0F0F, 32'h00E0_1234);
    run_case(1'b0, 17'h0, 16'h0, 2, 1'b1, 8'hFF, 1'b0, 1'b0,
             32'h0, 32'h0, 32'h0);
    run_case(1'b0, 17'h0, 16'h0, 1, 1'b0, 8'h08, 1'b1, 1'b0,
             32'h0123_4567, 32'h000A_AAAA, 32'h0015_5555);
    run_case(1'b0, 17'h0, 16'h0, 0, 1'b0, 8'hFF, 1'b0, 1'b0,
             32'h0, 32'h0, 32'h0);

    // Reset while a status read is on the bus.
    done_on = 0; hang = 1'b0; err_adr = 8'hFF; polls_seen = 0; n_resp = 0;
    log_q.delete();
    @(negedge wb_clk_i);
    start_i = 1'b1; load_i = 1'b0;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge wb_clk_i);
      if (wb_stb_o && !wb_we_o && n_resp >= 2) found = 1'b1;
    end
    check_eq("midpoll_found", 32'(found), 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    check_eq("arst_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("arst_stb", 32'(wb_stb_o), 32'd0);
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    check_eq("arst_done", 32'(done_o), 32'd0);
    check_eq("arst_status", 32'(status_o), 32'd0);
    check_eq("arst_sq", 32'(sq_o), 32'd0);
    check_eq("arst_gt", 32'(gt_o), 32'd0);
    check_eq("arst_lt", 32'(lt_o), 32'd0);
    exp_sq = '0; exp_gt = '0; exp_lt = '0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge wb_clk_i);
      if (done_o) ndone++;
    end
    check_eq("arst_no_done", 32'(ndone), 32'd0);
    run_case(1'b1, 17'h0_1234, 16'h5678, 2, 1'b0, 8'hFF, 1'b0, 1'b0,
             $urandom, $urandom, $urandom);

    for (int n = 0; n < 24; n++) begin
      int         r;
      logic [7:0] ea;
      r  = int'($urandom_range(0, 8));
      ea = (r < 6) ? adrs[r] : 8'hFF;
      run_case(1'($urandom), 17'($urandom), 16'($urandom), int'($urandom_range(0, 5)),
               ($urandom_range(0, 7) == 0), ea, 1'($urandom), 1'($urandom),
               $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
